// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// MDControl encodings and default operation latencies.
package md_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DZERO   = 3'd4
    } md_state_e;

    // MDControl select driven to the MD unit
    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    localparam int unsigned DEF_WIDTH       = 32;
    localparam int unsigned DEF_MULT_CYCLES = 33;
    localparam int unsigned DEF_DIV_CYCLES  = 33;
    localparam int unsigned DEF_CNT_W       = 6;

endpackage

// File: rtl/md_cycle_counter.sv
// Down-counter that times an MD operation (the MD unit has no done flag).
// Ports: clk, reset (async, active-high), load/load_val, dec, count, zero.
module md_cycle_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // load has priority over decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/md_hilo_ctrl.sv
// CPU-side sequencer for the multiply/divide unit. Latches a request,
// pulses start into the MD unit, times the operation, then captures the
// unit's HI/LO into the architectural HI/LO registers. Also handles
// divide-by-zero, abort flushes and mthi/mtlo writes.
// Ports: clk/reset; request side (req, op_div, a_in, b_in, abort);
// mthi/mtlo (hi_we, lo_we, wdata); MD unit side (md_a, md_b, md_sel,
// md_start, md_reset, md_hi, md_lo, md_div0); status (busy, done,
// div0_exc); architectural hi/lo.
module md_hilo_ctrl
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] md_a,
    output logic [WIDTH-1:0] md_b,
    output logic             md_sel,
    output logic             md_start,
    output logic             md_reset,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo,
    input  logic             md_div0,
    output logic             busy,
    output logic             done,
    output logic             div0_exc,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state;
    logic             abort_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;

    assign cnt_load = (state == ST_START) && !abort;
    assign cnt_dec  = (state == ST_RUN) && !abort && !cnt_zero;
    assign cnt_val  = (md_sel == MD_DIV) ? DIV_LOAD : MULT_LOAD;

    md_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (count),
        .zero     (cnt_zero)
    );

    // MD unit reset: system reset or a one-cycle flush pulse after abort
    assign md_reset = reset | abort_q;

    // Sequencer; status outputs are registered alongside the state they decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            md_a     <= '0;
            md_b     <= '0;
            md_sel   <= MD_MULT;
            md_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div0_exc <= 1'b0;
            abort_q  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            md_start <= 1'b0;
            done     <= 1'b0;
            div0_exc <= 1'b0;
            abort_q  <= 1'b0;

            // mthi/mtlo; a CAPTURE below overrides these in the same cycle
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;

            if (abort) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                abort_q <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            md_a   <= a_in;
                            md_b   <= b_in;
                            md_sel <= op_div;
                            busy   <= 1'b1;
                            if (op_div == MD_DIV && b_in == '0) begin
                                state    <= ST_DZERO;
                                div0_exc <= 1'b1;
                            end else begin
                                state    <= ST_START;
                                md_start <= 1'b1;
                            end
                        end
                    end
                    ST_START: begin
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        // backup divide-by-zero detection from the MD unit
                        if (md_sel == MD_DIV && md_div0) begin
                            state    <= ST_DZERO;
                            div0_exc <= 1'b1;
                        end else if (cnt_zero) begin
                            state <= ST_CAPTURE;
                            done  <= 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        hi    <= md_hi;
                        lo    <= md_lo;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    ST_DZERO: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed self-checking bench for md_hilo_ctrl with a fixed-latency
// behavioural multiply/divide unit.
module tb_md_hilo_ctrl;

    localparam int unsigned W      = 32;
    localparam int unsigned CYCLES = 33;

    logic         clk = 1'b0;
    logic         reset;
    logic         req, op_div, abort, hi_we, lo_we;
    logic [W-1:0] a_in, b_in, wdata;
    logic [W-1:0] md_a, md_b, md_hi, md_lo, hi, lo;
    logic         md_sel, md_start, md_reset, md_div0;
    logic         busy, done, div0_exc;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    md_hilo_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .op_div   (op_div),
        .a_in     (a_in),
        .b_in     (b_in),
        .abort    (abort),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_sel   (md_sel),
        .md_start (md_start),
        .md_reset (md_reset),
        .md_hi    (md_hi),
        .md_lo    (md_lo),
        .md_div0  (md_div0),
        .busy     (busy),
        .done     (done),
        .div0_exc (div0_exc),
        .hi       (hi),
        .lo       (lo)
    );

    // Behavioural MD unit: results valid CYCLES cycles after the start pulse,
    // junk before that so an early capture is visible.
    logic [W-1:0]   mdl_a, mdl_b;
    logic           mdl_sel;
    int             mdl_cnt;
    logic [2*W-1:0] prod;

    assign prod    = $signed({{W{mdl_a[W-1]}}, mdl_a}) * $signed({{W{mdl_b[W-1]}}, mdl_b});
    assign md_div0 = 1'b0;

    always @(posedge clk or posedge md_reset) begin
        if (md_reset) begin
            mdl_cnt <= 0;
            md_hi   <= 32'hDEAD_BEEF;
            md_lo   <= 32'hDEAD_BEEF;
        end else if (md_start) begin
            mdl_a   <= md_a;
            mdl_b   <= md_b;
            mdl_sel <= md_sel;
            mdl_cnt <= CYCLES;
            md_hi   <= 32'hDEAD_BEEF;
            md_lo   <= 32'hDEAD_BEEF;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                if (mdl_sel) begin
                    md_hi <= W'($signed(mdl_a) % $signed(mdl_b));
                    md_lo <= W'($signed(mdl_a) / $signed(mdl_b));
                end else begin
                    md_hi <= prod[2*W-1:W];
                    md_lo <= prod[W-1:0];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (done)     done_cnt++;
        if (md_start) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one clock, land 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present a request for one edge (edge T0); returns in cycle T0+1
    task automatic issue(input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
        req    = 1'b1;
        op_div = div;
        a_in   = a;
        b_in   = b;
        step();
        req = 1'b0;
    endtask

    // n enters as the current cycle index relative to T0; leaves on the done cycle
    task automatic wait_done(input int start, output int n);
        n = start;
        while (!done && n < 100) begin
            step();
            n++;
        end
    endtask

    int n, s, d;

    initial begin
        reset = 1'b1;
        req = 1'b0; op_div = 1'b0; abort = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0;
        a_in = '0; b_in = '0; wdata = '0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mdreset", 32'(md_reset), 32'd1);
        chk("rst_start", 32'(md_start), 32'd0);
        reset = 1'b0;
        step();
        chk("mdreset_rel", 32'(md_reset), 32'd0);

        // multiply 7*6
        issue(1'b0, 32'd7, 32'd6);
        chk("mul_start", 32'(md_start), 32'd1);
        chk("mul_busy", 32'(busy), 32'd1);
        chk("mul_sel", 32'(md_sel), 32'd0);
        chk("mul_a", md_a, 32'd7);
        chk("mul_b", md_b, 32'd6);
        step();
        chk("mul_start_1cyc", 32'(md_start), 32'd0);
        wait_done(2, n);
        chk("mul_lat", 32'(n), 32'd35);
        chk("mul_busy_done", 32'(busy), 32'd1);
        step();
        chk("mul_hi", hi, 32'd0);
        chk("mul_lo", lo, 32'd42);
        chk("mul_idle", 32'(busy), 32'd0);
        chk("mul_done_1cyc", 32'(done), 32'd0);

        // signed multiply -1*2; an mthi coinciding with CAPTURE loses
        issue(1'b0, 32'hFFFF_FFFF, 32'd2);
        wait_done(1, n);
        chk("neg_lat", 32'(n), 32'd35);
        hi_we = 1'b1;
        wdata = 32'h1234;
        step();
        hi_we = 1'b0;
        chk("neg_hi", hi, 32'hFFFF_FFFF);
        chk("neg_lo", lo, 32'hFFFF_FFFE);

        // divide 100/7
        issue(1'b1, 32'd100, 32'd7);
        chk("div_sel", 32'(md_sel), 32'd1);
        wait_done(1, n);
        chk("div_lat", 32'(n), 32'd35);
        step();
        chk("div_hi", hi, 32'd2);
        chk("div_lo", lo, 32'd14);

        // mtlo in IDLE
        lo_we = 1'b1;
        wdata = 32'h55;
        step();
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h55);
        chk("mtlo_hi", hi, 32'd2);

        // divide by zero with hi preset
        hi_we = 1'b1;
        wdata = 32'h11;
        step();
        hi_we = 1'b0;
        s = start_cnt;
        d = done_cnt;
        issue(1'b1, 32'd5, 32'd0);
        chk("dz_exc", 32'(div0_exc), 32'd1);
        chk("dz_start", 32'(md_start), 32'd0);
        chk("dz_busy", 32'(busy), 32'd1);
        step();
        chk("dz_exc_1cyc", 32'(div0_exc), 32'd0);
        chk("dz_idle", 32'(busy), 32'd0);
        repeat (3) step();
        chk("dz_hi", hi, 32'h11);
        chk("dz_nostart", 32'(start_cnt), 32'(s));
        chk("dz_nodone", 32'(done_cnt), 32'(d));

        // abort mid-RUN, then a fresh divide 50/7
        d = done_cnt;
        issue(1'b1, 32'd100, 32'd7);
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_mdreset", 32'(md_reset), 32'd1);
        chk("ab_hi", hi, 32'h11);
        chk("ab_lo", lo, 32'h55);
        step();
        chk("ab_mdreset_1cyc", 32'(md_reset), 32'd0);
        issue(1'b1, 32'd50, 32'd7);
        wait_done(1, n);
        chk("ab_re_lat", 32'(n), 32'd35);
        step();
        chk("ab_re_hi", hi, 32'd1);
        chk("ab_re_lo", lo, 32'd7);
        chk("ab_done_cnt", 32'(done_cnt), 32'(d + 1));

        // simultaneous abort and req in IDLE: request dropped
        s = start_cnt;
        req = 1'b1; abort = 1'b1; op_div = 1'b0; a_in = 32'd3; b_in = 32'd3;
        step();
        req = 1'b0; abort = 1'b0;
        chk("abreq_busy", 32'(busy), 32'd0);
        chk("abreq_mdreset", 32'(md_reset), 32'd1);
        step();
        chk("abreq_nostart", 32'(start_cnt), 32'(s));

        // mthi during RUN is overwritten by CAPTURE (3*5)
        issue(1'b0, 32'd3, 32'd5);
        repeat (4) step();
        hi_we = 1'b1;
        wdata = 32'hAAAA;
        step();
        hi_we = 1'b0;
        chk("mthi_run_hi", hi, 32'hAAAA);
        wait_done(6, n);
        chk("mthi_lat", 32'(n), 32'd35);
        step();
        chk("mthi_cap_hi", hi, 32'd0);
        chk("mthi_cap_lo", lo, 32'd15);

        // async reset mid-RUN
        issue(1'b0, 32'd9, 32'd9);
        repeat (7) step();
        chk("ar_busy_pre", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_hi", hi, 32'd0);
        chk("ar_lo", lo, 32'd0);
        chk("ar_mdreset", 32'(md_reset), 32'd1);
        step();
        reset = 1'b0;
        d = done_cnt;
        repeat (40) step();
        chk("ar_nodone", 32'(done_cnt), 32'(d));
        chk("ar_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_hilo_ctrl.md
Name: md_hilo_ctrl

Overview:
Sequencer on the CPU side of the multiply/divide unit. Accepts a mult/div request from the main control unit and drives operands, MDControl select and the start pulse into the MD unit. That unit has no done flag, so this block times the operation with a cycle counter. On completion it captures the unit's HI/LO outputs into the architectural HI/LO registers, and it handles divide-by-zero, abort and mthi/mtlo writes.

Parameters:
WIDTH, 32, operand/result width
MULT_CYCLES, 33, cycles from start pulse until multiplier HI/LO are valid
DIV_CYCLES, 33, cycles from start pulse until divider HI/LO are valid
CNT_W, 6, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  1  request one operation (sampled in IDLE only)
op_div  in  1  0 = multiply, 1 = divide (sampled with req)
a_in  in  WIDTH  operand A / dividend
b_in  in  WIDTH  operand B / divisor
abort  in  1  cancel the in-flight operation (exception flush)
hi_we  in  1  mthi write strobe
lo_we  in  1  mtlo write strobe
wdata  in  WIDTH  mthi/mtlo data
md_a  out  WIDTH  operand A to MD unit (registered)
md_b  out  WIDTH  operand B to MD unit (registered)
md_sel  out  1  MDControl to MD unit (registered op_div)
md_start  out  1  one-cycle start pulse
md_reset  out  1  MD unit reset = reset OR abort-pulse
md_hi  in  WIDTH  MD unit HI result
md_lo  in  WIDTH  MD unit LO result
md_div0  in  1  MD unit divide-by-zero flag
busy  out  1  operation in flight; control unit stalls mfhi/mflo and new req
done  out  1  one-cycle pulse, HI/LO updated at this edge
div0_exc  out  1  one-cycle divide-by-zero exception pulse
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO

Behaviour:
- Reset (async): state=IDLE; counter, md_a, md_b, md_sel, hi, lo = 0. busy, done, div0_exc and md_start are 0. md_reset=1 while reset is high.
- States: IDLE, START, RUN, CAPTURE, DZERO. Outputs are decoded from state: md_start=(START), busy=(state!=IDLE), done=(CAPTURE), div0_exc=(DZERO).
- IDLE: on req, latch a_in, b_in, op_div into md_a, md_b, md_sel.
  - If op_div=1 and b_in=0, go to DZERO. Otherwise go to START.
  - req in any other state is ignored; the control unit holds off on busy.
- DZERO: single cycle, then IDLE. md_start is never asserted and hi/lo are unchanged.
- START: single cycle. Load counter = (md_sel ? DIV_CYCLES : MULT_CYCLES) - 1. Go to RUN.
- RUN: decrement the counter.
  - If md_div0=1 while md_sel=1, go to DZERO (backup detection).
  - When the counter is 0, go to CAPTURE.
- CAPTURE: hi<=md_hi and lo<=md_lo at this edge. Go to IDLE.
- Latency: with req sampled at edge T0, done is high during cycle T0+CYCLES+2 and hi/lo hold the result from T0+CYCLES+3. req is accepted again from that same cycle.
- mthi/mtlo:
  - hi_we/lo_we write wdata in any state.
  - If a write coincides with CAPTURE, CAPTURE wins.
  - A write during START/RUN is overwritten by the following CAPTURE (MIPS semantics).
- abort: highest priority after reset, in any state. Next state is IDLE, and a one-cycle md_reset pulse is registered. hi/lo are unchanged and no done or div0_exc pulse is raised.
- Simultaneous abort and req in IDLE: abort wins and the request is dropped.
- Arithmetic: this block performs no arithmetic. Width checks are b_in==0 (full WIDTH) and counter==0.

Decomposition:
- Shared package md_pkg holds:
  - state encoding constants (IDLE=0 … DZERO=4)
  - MDControl encodings MD_MULT=0, MD_DIV=1
  - default cycle counts
- The counter is natural as a sub-module md_cycle_counter: load, decrement, zero flag; the state machine stays in md_hilo_ctrl.
- The bench drives md_hi/md_lo/md_div0 from a behavioural MD model that has a fixed latency.

Test Plan:
- Multiply: req, op_div=0, a=7, b=6 -> md_start pulses at T0+1; done at T0+35; then hi=0, lo=42; busy high T0+1..T0+35.
- Signed multiply carry into HI: a=0xFFFFFFFF (-1), b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE after done.
- Divide: req, op_div=1, a=100, b=7 -> md_sel=1; done at T0+35; hi=2 (remainder), lo=14 (quotient).
- Divide by zero: a=5, b=0, hi preset to 0x11 -> div0_exc pulses at T0+1, md_start never high, hi stays 0x11, no done.
- Abort mid-RUN: start a divide, assert abort at T0+10 -> md_reset pulses once, state IDLE, no done, hi/lo unchanged. A new req at T0+12 completes normally.
- mthi during RUN, then async reset mid-RUN: hi_we with 0xAAAA at T0+5 is overwritten at CAPTURE. Async reset at T0+8 clears busy, hi and lo immediately, with no done afterwards.
